sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised synchronous single-clock FIFO that supersedes the fixed 32-bit, 2-entry command buffer between the host-interface decoder and the motor step generators. It adds configurable width and depth, selectable standard or first-word-fall-through (FWFT) read mode, and almost-full/almost-empty thresholds for flow control. It also provides a synchronous flush, simultaneous read/write when full, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 32, data word width in bits
- ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W, legal 1..8
- AFULL_TH, DEPTH-1, almost_full asserted when count >= AFULL_TH
- AEMPTY_TH, 1, almost_empty asserted when count <= AEMPTY_TH
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request (FWFT: pop acknowledge)
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data holds a valid word
- full, empty  out  1 each  occupancy flags
- almost_full, almost_empty  out  1 each  threshold flags
- count  out  ADDR_W+1  words stored, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Reset values: count 0, pointers 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0.
- Accept rules: wr_acc = wr_en & (!full | rd_acc); rd_acc = rd_en & !empty.
- When full, a simultaneous read and write are both accepted; count is unchanged.
- When empty, a simultaneous read and write accept only the write; count becomes 1.
- Rejected write (wr_en & !wr_acc) sets overflow; data is dropped and memory is untouched.
- Rejected read (rd_en & empty) sets underflow; rd_data is unchanged.
- count: +1 on write-only, -1 on read-only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Flags are combinational decodes of registered count: empty = (count==0), full = (count==DEPTH), plus the thresholds.
- flush has priority over wr_en, rd_en and err_clr. It zeroes count and pointers, sets rd_valid to 0 and does not write memory. rd_data holds its last value; overflow and underflow are preserved.
- err_clr clears both sticky flags; an error event in the same cycle wins (flag stays set).
- Standard mode (FWFT=0): rd_data is registered and loaded with the head word on rd_acc. rd_valid is a one-cycle pulse the cycle after rd_acc.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] combinationally; rd_valid = !empty; rd_acc consumes the displayed word.
- rst asserted mid-operation discards contents immediately, with all outputs at reset values.

## Timing
- Write-to-empty-deasserted latency: 1 cycle (flag valid after the edge that accepts the write).
- Standard read latency: rd_data/rd_valid valid 1 cycle after rd_en is sampled.
- FWFT read latency: first written word visible on rd_data 1 cycle after the write edge.
- Full back-to-back throughput: one write and one read per cycle.
- Memory write and pointer update occur on the same edge; read-during-write to the same address is impossible except when full with simultaneous read and write (read returns the old word).

## Structure
- Shared package/header fifo_pkg: default DATA_W/ADDR_W constants, FWFT mode encodings, count width function clog2.
- One sub-module fifo_mem: DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port. The top level holds pointers, count, flags and the output register.

## Test plan
- DATA_W=32, ADDR_W=2, FWFT=0: write 0xA0..0xA3 -> full=1, count=4; write 0xFF -> overflow=1; read 4x -> rd_data 0xA0..0xA3 each one cycle later, empty=1.
- Full FIFO, rd_en=wr_en=1 with 0xB5 for one cycle -> count stays 4, overflow=0; subsequent drain ends with 0xB5.
- Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0; err_clr pulse -> underflow=0; err_clr concurrent with new underflow -> underflow=1.
- FWFT=1: write 0x11 -> next cycle rd_valid=1, rd_data=0x11 with no rd_en; rd_en pulse -> empty=1, rd_valid=0.
- AFULL_TH=3, AEMPTY_TH=1: fill 0->4 -> almost_empty high at counts 0,1; almost_full high at 3,4; 6 write/read cycles exercise pointer wrap with data order preserved.
- count=3, then flush with wr_en=1 -> count=0, empty=1, write ignored. Async rst mid-stream -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: shared constants for the parametrised command FIFO.
//   DEF_DATA_W / DEF_ADDR_W : default word and pointer widths
//   FWFT_STD / FWFT_FALL    : read-mode encodings for the FWFT parameter
//   clog2()                 : bits needed to hold values 0..v-1
package sync_fifo_param_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  localparam int FWFT_STD  = 0;  // registered read, one-cycle rd_valid pulse
  localparam int FWFT_FALL = 1;  // head word always presented on rd_data

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: FIFO handshake bundle.
//   master : producer/consumer side (drives flush, wr_*, rd_en, err_clr)
//   slave  : FIFO side (drives rd_data, rd_valid, flags, count, errors)
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param_mem.sv
// sync_fifo_param_mem: DEPTH x DATA_W register array.
//   clk, rst      : clock, async active-high reset
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : asynchronous read port
module sync_fifo_param_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Cleared on reset so a fall-through read port shows 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with standard or
// first-word-fall-through read, threshold flags, flush and sticky errors.
//   clk, rst : clock, async active-high reset
//   bus      : sync_fifo_param_if.slave (write/read handshake, flags,
//              count, overflow/underflow, flush, err_clr)
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = (1 << ADDR_W) - 1,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = FWFT_STD
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] head;
  logic              wr_acc, rd_acc, ovf_set, udf_set;
  logic              ovf, udf;

  // Flush masks every request, so nothing is accepted or flagged that cycle.
  // A write into a full FIFO is allowed when the same cycle pops a word.
  assign rd_acc  = bus.rd_en & ~bus.flush & ~bus.empty;
  assign wr_acc  = bus.wr_en & ~bus.flush & (~bus.full | rd_acc);
  assign ovf_set = bus.wr_en & ~bus.flush & ~wr_acc;
  assign udf_set = bus.rd_en & ~bus.flush & bus.empty;

  assign bus.count        = cnt;
  assign bus.empty        = (cnt == '0);
  assign bus.full         = (cnt == CNT_W'(DEPTH));
  assign bus.almost_full  = (cnt >= CNT_W'(AFULL_TH));
  assign bus.almost_empty = (cnt <= CNT_W'(AEMPTY_TH));
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;

  sync_fifo_param_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers wrap naturally at ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky errors: a fresh event beats err_clr; flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (!bus.flush) begin
      ovf <= ovf_set | (ovf & ~bus.err_clr);
      udf <= udf_set | (udf & ~bus.err_clr);
    end
  end

  generate
    if (FWFT == FWFT_FALL) begin : g_fwft
      assign bus.rd_data  = head;
      assign bus.rd_valid = ~bus.empty;
    end else begin : g_std
      logic [DATA_W-1:0] rd_q;
      logic              vld_q;
      // The head is captured before the same edge can overwrite it, so a
      // read+write while full returns the old word.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_q  <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= rd_acc;
          if (rd_acc) rd_q <= head;
        end
      end
      assign bus.rd_data  = rd_q;
      assign bus.rd_valid = vld_q;
    end
  endgenerate
endmodule
